// File: rtl/load_store_unit.sv
// load_store_unit: M-stage data-memory interface. Checks size/alignment, issues a
// single request per load/store, stalls the pipeline until the memory answers (or a
// timeout expires), and formats load data.
// Ports:
//   clk, reset                 - clock, asynchronous active-high reset
//   MemReadM, MemWriteM        - M-stage load / store
//   InstrM[2:0]                - funct3 (size and sign)
//   ALUResultM, WriteDataM     - byte address, right-aligned store data
//   DReq, DWe, DAddr, DWData,
//   DWStrb                     - memory request (DReq combinational)
//   DRData, DReady             - memory response
//   ReadDataM                  - formatted load result (registered)
//   StallM                     - pipeline freeze (combinational)
//   FaultM, BusErrM            - one-cycle fault / timeout pulses (registered)
module load_store_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  InstrM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic        DReq,
  output logic        DWe,
  output logic [31:0] DAddr,
  output logic [31:0] DWData,
  output logic [3:0]  DWStrb,
  input  logic [31:0] DRData,
  input  logic        DReady,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        FaultM,
  output logic        BusErrM
);

  localparam int unsigned CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          access;
  logic          legal;
  logic          aligned;
  logic          go;
  logic          timed_out;
  logic [7:0]    rbyte;
  logic [15:0]   rhalf;
  logic [31:0]   load_fmt;

  // Access classification
  always_comb begin
    access  = MemReadM | MemWriteM;
    legal   = 1'b0;
    aligned = 1'b0;
    unique case (InstrM)
      3'b000, 3'b001, 3'b010: legal = ~(MemReadM & MemWriteM);
      3'b100, 3'b101:         legal = MemReadM & ~MemWriteM;
      default:                legal = 1'b0;
    endcase
    unique case (InstrM[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~ALUResultM[0];
      2'b10:   aligned = (ALUResultM[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
    go = access & legal & aligned;
  end

  // Reset gating drops an in-flight request in the same cycle reset rises
  assign DReq   = ~reset & (((state == IDLE) & go) | (state == BUSY));
  assign StallM = DReq;
  assign DWe    = MemWriteM;
  assign DAddr  = {ALUResultM[31:2], 2'b00};

  // Write lane replication and strobes
  always_comb begin
    DWData = WriteDataM;
    DWStrb = 4'b0000;
    unique case (InstrM[1:0])
      2'b00:   DWData = {4{WriteDataM[7:0]}};
      2'b01:   DWData = {2{WriteDataM[15:0]}};
      default: DWData = WriteDataM;
    endcase
    if (MemWriteM) begin
      unique case (InstrM)
        3'b000:  DWStrb = 4'b0001 << ALUResultM[1:0];
        3'b001:  DWStrb = ALUResultM[1] ? 4'b1100 : 4'b0011;
        3'b010:  DWStrb = 4'b1111;
        default: DWStrb = 4'b0000;
      endcase
    end
  end

  // Load lane extraction and sign/zero extension
  always_comb begin
    rbyte    = DRData[7:0];
    rhalf    = ALUResultM[1] ? DRData[31:16] : DRData[15:0];
    load_fmt = DRData;
    unique case (ALUResultM[1:0])
      2'b00:   rbyte = DRData[7:0];
      2'b01:   rbyte = DRData[15:8];
      2'b10:   rbyte = DRData[23:16];
      default: rbyte = DRData[31:24];
    endcase
    unique case (InstrM)
      3'b000:  load_fmt = {{24{rbyte[7]}}, rbyte};
      3'b001:  load_fmt = {{16{rhalf[15]}}, rhalf};
      3'b100:  load_fmt = {24'h0, rbyte};
      3'b101:  load_fmt = {16'h0, rhalf};
      default: load_fmt = DRData;
    endcase
  end

  assign timed_out = (cnt >= CW'(TIMEOUT));

  // Control FSM with registered result and pulse outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      ReadDataM <= '0;
      FaultM    <= 1'b0;
      BusErrM   <= 1'b0;
    end else begin
      FaultM  <= 1'b0;
      BusErrM <= 1'b0;
      unique case (state)
        IDLE: begin
          if (go) begin
            state <= BUSY;
            cnt   <= '0;
          end else if (access) begin
            FaultM <= 1'b1;
          end
        end
        BUSY: begin
          if (DReady) begin
            if (MemReadM) ReadDataM <= load_fmt;
            state <= DONE;
          end else if (timed_out) begin
            BusErrM   <= 1'b1;
            ReadDataM <= '0;
            state     <= DONE;
          end else if (cnt != '1) begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
